// File: rtl/shift_add_mult.sv
// Sequential unsigned multiplier: one shift-and-add step per cycle over the latched
// operands, then a one-cycle done strobe with the product held in a register.
module shift_add_mult #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]     product_q, product_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [PW-1:0]     pp;
    logic [PW-1:0]     acc_sum;

    always_comb begin
        pp      = PW'(a_q & {WIDTH{b_q[cnt_q]}}) << cnt_q;
        acc_sum = acc_q + pp;

        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        case (state_q)
            IDLE, DONE: begin
                // DONE accepts start too, so back-to-back operations have no idle gap
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                acc_d = acc_sum;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    product_d = acc_sum;
                    state_d   = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == BUSY);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: doc/shift_add_mult.md
SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, the operand width in bits; product width is 2*WIDTH.
REQ-002 The block SHALL have port clk, input, 1, the sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, request to begin a multiply.
REQ-005 The block SHALL have port a, input, WIDTH, multiplicand.
REQ-006 The block SHALL have port b, input, WIDTH, multiplier.
REQ-007 The block SHALL have port busy, output, 1, high while a multiply is in progress.
REQ-008 The block SHALL have port done, output, 1, one-cycle completion strobe.
REQ-009 The block SHALL have port product, output, 2*WIDTH, unsigned a*b result, registered.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, BUSY, DONE.
REQ-011 In IDLE or DONE, start=1 at a rising edge SHALL latch a and b into internal registers, clear the accumulator, clear the bit counter and enter BUSY.
REQ-012 Operands SHALL be sampled only at the accepting edge; changes to a/b afterwards SHALL NOT affect the result.
REQ-013 In BUSY, each cycle SHALL form the partial product (latched a) AND-ed bitwise with the single latched-b bit selected by the counter, zero-extend it to 2*WIDTH, shift it left by the counter value, and add it to the accumulator.
REQ-014 The accumulator SHALL be 2*WIDTH bits; the sum never overflows for unsigned operands, and no carry-out is kept.
REQ-015 The counter SHALL increment by 1 per BUSY cycle; the cycle with counter = WIDTH-1 SHALL be the last add, after which the FSM enters DONE.
REQ-016 On entering DONE, product SHALL load the final accumulator value; product SHALL then hold until the next DONE entry.
REQ-017 done SHALL be 1 exactly during the DONE cycle and 0 otherwise; busy SHALL be 1 exactly during BUSY cycles.
REQ-018 Latency: start accepted at edge k gives busy=1 for cycles k+1..k+WIDTH and done=1 in cycle k+WIDTH+1 (k+5 for WIDTH=4).
REQ-019 DONE without start SHALL return to IDLE after one cycle.
REQ-020 start=1 during DONE SHALL be accepted (back-to-back operation, no idle gap); done and the new busy SHALL never be high in the same cycle.
REQ-021 start=1 during BUSY SHALL be ignored: no restart, no re-latching, and no queued request.
REQ-022 Bits of b that are zero SHALL still take one cycle each; there is no early termination.

Reset
REQ-023 While rst=1, the block SHALL immediately, independent of clk, force state=IDLE, busy=0, done=0, product=0, accumulator=0, counter=0 and latched operands=0.
REQ-024 Reset asserted mid-BUSY SHALL abort the operation; no done pulse SHALL follow and product SHALL read 0.
REQ-025 After rst deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-026 Reset, then a=0xA, b=0x3, start pulse at edge k -> busy=1 in cycles k+1..k+4, done=1 in cycle k+5, product=0x1E held after.
REQ-027 a=0xF, b=0xF -> product=0xE1; then a=0x0, b=0xF -> product=0x00; then a=0x7, b=0x0 -> product=0x00.
REQ-028 start held high continuously with a=0x5, b=0x6 -> done every 5 cycles, product=0x1E each time, busy low in each done cycle.
REQ-029 Accept a=0x9, b=0x9; pulse start with a=0x2, b=0x2 and change a/b during BUSY -> start ignored, product=0x51, single done pulse.
REQ-030 Accept a=0xC, b=0xB; assert rst asynchronously (between clock edges) in the 2nd BUSY cycle -> busy, done and product go to 0 at once; no done appears; next accepted operation a=0x3, b=0x4 gives product=0x0C.
REQ-031 Exhaustive sweep of all 256 a/b pairs with back-to-back starts -> every product equals a*b, and each done is exactly 5 cycles after its accepting edge.
